// File: rtl/systolic_array_pkg.sv
// systolic_array_pkg: shared word type, default depth, scratchpad FSM states and range helper
package systolic_array_pkg;
  typedef logic [31:0] word_t;
  localparam int DEPTH_DEF = 256;
  typedef enum logic {INIT, READY} scratch_state_t;
  function automatic logic addr_ok(word_t a, int unsigned depth);
    return a < depth;
  endfunction
endpackage

// File: rtl/scratch_clear_ctrl.sv
// scratch_clear_ctrl: INIT/READY FSM sweeping a clear pointer across every word after reset
module scratch_clear_ctrl
  import systolic_array_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  output scratch_state_t state,
  output logic [AW-1:0]  ptr
);
  scratch_state_t state_n;
  logic [AW-1:0] ptr_n;
  always_ff @(posedge clk)
    if (rst) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  always_comb begin
    state_n = (state == INIT && ptr == AW'(DEPTH - 1)) ? READY : state;
    ptr_n   = (state == INIT) ? ptr + AW'(1) : ptr;
  end
endmodule

// File: rtl/systolic_scratchpad.sv
// systolic_scratchpad: N-port X/W operand scratchpad with self-clear; SCRATCHPAD_FWD_EN forwards same-cycle writes to reads
module systolic_scratchpad
  import systolic_array_pkg::*;
#(
  parameter int N = 4,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     rd_x_valid,
  input  word_t [N-1:0]    rd_x_addr,
  input  logic [N-1:0]     rd_w_valid,
  input  word_t [N-1:0]    rd_w_addr,
  output word_t [N-1:0]    rd_x_data,
  output word_t [N-1:0]    rd_w_data,
  output logic [2*N-1:0]   rd_data_valid,
  input  logic [N-1:0]     wr_valid,
  input  word_t [N-1:0]    wr_addr,
  input  word_t [N-1:0]    wr_data,
  output logic             init_busy,
  output logic             addr_err
);
  localparam int AW = $clog2(DEPTH);
  word_t mem [DEPTH];
  scratch_state_t state;
  logic [AW-1:0] ptr;
  logic ready, err;
  logic [2*N-1:0] rd_req;
  word_t [2*N-1:0] rd_addr, rd_word, rd_q;
  scratch_clear_ctrl #(.DEPTH(DEPTH)) u_clr (.clk(clk), .rst(rst), .state(state), .ptr(ptr));
  assign ready     = state == READY;
  assign init_busy = state == INIT;
  assign rd_req    = {rd_w_valid, rd_x_valid};
  assign rd_addr   = {rd_w_addr, rd_x_addr};
  assign rd_x_data = rd_q[N-1:0];
  assign rd_w_data = rd_q[2*N-1:N];
  always_comb begin
    err = 1'b0;
    for (int p = 0; p < 2*N; p++) begin
      rd_word[p] = mem[rd_addr[p][AW-1:0]];
`ifdef SCRATCHPAD_FWD_EN
      for (int j = 0; j < N; j++)
        if (wr_valid[j] && addr_ok(wr_addr[j], DEPTH) && wr_addr[j][AW-1:0] == rd_addr[p][AW-1:0])
          rd_word[p] = wr_data[j];
`endif
      rd_word[p] = addr_ok(rd_addr[p], DEPTH) ? rd_word[p] : '0;
      err |= rd_req[p] && !addr_ok(rd_addr[p], DEPTH);
    end
    for (int j = 0; j < N; j++)
      err |= wr_valid[j] && !addr_ok(wr_addr[j], DEPTH);
  end
  always_ff @(posedge clk)
    if (!rst) begin
      if (!ready) mem[ptr] <= '0;
      else
        for (int j = 0; j < N; j++)
          if (wr_valid[j] && addr_ok(wr_addr[j], DEPTH)) mem[wr_addr[j][AW-1:0]] <= wr_data[j];
    end
  always_ff @(posedge clk)
    if (rst) begin
      rd_q          <= '0;
      rd_data_valid <= '0;
      addr_err      <= 1'b0;
    end else begin
      for (int p = 0; p < 2*N; p++) begin
        rd_data_valid[p] <= ready && rd_req[p];
        rd_q[p]          <= (ready && rd_req[p]) ? rd_word[p] : '0;
      end
      addr_err <= addr_err | (ready & err);
    end
endmodule

// File: doc/systolic_scratchpad.md
SYSTOLIC_SCRATCHPAD -- requirements
Module: systolic_scratchpad

Interface
REQ-001 SHALL have parameter N, default 4, number of read-port pairs and write ports; power of two, at least 2.
REQ-002 SHALL have parameter DEPTH, default 256, number of 32-bit words; power of two.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports rd_x_valid (input, N) and rd_x_addr (input, N x 32): X-operand read requests, one per port.
REQ-006 SHALL have ports rd_w_valid (input, N) and rd_w_addr (input, N x 32): W-operand read requests.
REQ-007 SHALL have ports rd_x_data and rd_w_data, output, N x 32, registered read data.
REQ-008 SHALL have port rd_data_valid, output, 2N, registered; [i] = X port i, [N+i] = W port i.
REQ-009 SHALL have ports wr_valid (input, N), wr_addr (input, N x 32) and wr_data (input, N x 32): result and controller writes.
REQ-010 SHALL have port init_busy, output, 1, high while the memory clear runs.
REQ-011 SHALL have port addr_err, output, 1, sticky flag for an out-of-range access.

Function
REQ-012 SHALL use word addressing; an address is in range iff addr < DEPTH; index = addr[log2(DEPTH)-1:0].
REQ-013 SHALL use a two-state FSM: INIT and READY; rst forces INIT with clear pointer 0.
REQ-014 SHALL, in INIT, write 0 to word[ptr] each cycle, increment ptr, and enter READY on the cycle ptr = DEPTH-1 is written (DEPTH cycles total).
REQ-015 SHALL hold init_busy = 1 exactly while in INIT.
REQ-016 SHALL ignore all read and write requests in INIT; rd_data_valid stays 0 and memory is unaffected by wr_*.
REQ-017 SHALL, in READY, return read data with one-cycle latency: a request at edge k is returned on rd_*_data and rd_data_valid in the cycle after edge k.
REQ-018 SHALL drive rd_*_data[i] = 0 and rd_data_valid bit = 0 when the corresponding request was not valid; data is not held.
REQ-019 SHALL return 0 data with valid = 1 for an in-range-failing read, and set addr_err.
REQ-020 SHALL commit in-range writes at the clock edge; out-of-range writes are dropped and set addr_err.
REQ-021 SHALL, when several wr ports target the same index in one cycle, let the highest port index win.
REQ-022 SHALL allow any number of ports to read the same index in one cycle, all receiving identical data.
REQ-023 SHALL keep addr_err set until rst; it is not set by requests made during INIT.

Reset
REQ-024 SHALL, on rst, set rd_x_data = 0, rd_w_data = 0, rd_data_valid = 0, addr_err = 0, init_busy = 1 (from the next cycle), and restart the clear.
REQ-025 SHALL, if rst is asserted mid-INIT or mid-traffic, discard in-flight reads and restart the clear from ptr 0.

Configuration
REQ-026 SHALL support macro SCRATCHPAD_FWD_EN for same-cycle read/write to the same index.
- Defined: read returns the new write data, after the REQ-021 winner is applied.
- Undefined: read returns the old contents.

Structure
REQ-027 SHALL take word_t, the default DEPTH, and the FSM state enum scratch_state_t from systolic_array_pkg.
REQ-028 SHALL keep the storage array inline with no sub-module; the optional sub-module scratch_clear_ctrl holds the INIT FSM and pointer.

Verification
REQ-029 Reset test: assert rst 1 cycle, then release -> init_busy high for exactly DEPTH=256 cycles; a read of addr 17 afterwards returns 0 with valid = 1.
REQ-030 Latency test: write 0xDEADBEEF to addr 5; next cycle read X0 addr 5 -> rd_x_data[0] = 0xDEADBEEF one cycle later, rd_data_valid[0] = 1.
REQ-031 Write-conflict test: wr ports 0..3 all target addr 9 with data 1, 2, 3, 4 in one cycle; read addr 9 -> returns 4.
REQ-032 Range test: read addr 300 (DEPTH=256) -> data 0, valid = 1, addr_err = 1 and still 1 after 10 idle cycles.
REQ-033 Forwarding test: addr 3 holds 7; write 8 to addr 3 and read addr 3 in the same cycle -> returns 8 with SCRATCHPAD_FWD_EN, 7 without.
REQ-034 Mid-operation reset test: assert rst during streamed 4x4 operand reads -> rd_data_valid = 0 the next cycle, init_busy = 1, previously written addr 5 reads 0 after the clear.
